// File: rtl/prog_loader.sv
// Program loader: receives a framed byte stream (count, big-endian words, XOR checksum),
// writes the words into MIPS instruction memory, then releases the core from reset.
module prog_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        ProgMode,
  output logic [7:0]  Addr_Prog,
  output logic [31:0] Data_Prog,
  output logic        prog_we,
  output logic        cpu_reset,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    RUN_RST,
    RUN
  } state_t;

  state_t      state_q,     state_d;
  logic [7:0]  count_q,     count_d;
  logic [7:0]  word_addr_q, word_addr_d;
  logic [1:0]  byte_idx_q,  byte_idx_d;
  logic [23:0] shift_q,     shift_d;
  logic [7:0]  acc_q,       acc_d;
  logic        rst_cnt_q,   rst_cnt_d;
  logic [7:0]  addr_q,      addr_d;
  logic [31:0] data_q,      data_d;
  logic        we_q,        we_d;
  logic        err_q,       err_d;
  logic        hs;

  assign hs = rx_valid & rx_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    rst_cnt_d   = rst_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    we_d        = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      IDLE, RUN: begin
        if (start) begin
          state_d     = COUNT;
          err_d       = 1'b0;
          word_addr_d = '0;
          acc_d       = '0;
          byte_idx_d  = '0;
        end
      end
      COUNT: begin
        if (hs) begin
          count_d = rx_data;
          state_d = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          acc_d      = acc_q ^ rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            data_d      = {shift_q, rx_data};
            addr_d      = word_addr_q;
            we_d        = 1'b1;
            word_addr_d = word_addr_q + 8'd1;
            // count 0 means 256 words: count-1 wraps to 255, the last address
            if (word_addr_q == (count_q - 8'd1)) begin
              state_d = CHECK;
            end
          end else begin
            shift_d = {shift_q[15:0], rx_data};
          end
        end
      end
      CHECK: begin
        if (hs) begin
          if (rx_data == acc_q) begin
            state_d   = RUN_RST;
            rst_cnt_d = 1'b0;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RUN_RST: begin
        rst_cnt_d = 1'b1;
        if (rst_cnt_q) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      word_addr_q <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      acc_q       <= '0;
      rst_cnt_q   <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_addr_q <= word_addr_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      rst_cnt_q   <= rst_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      err_q       <= err_d;
    end
  end

  // Handshake-facing and core-control outputs are pure state decodes
  assign rx_ready  = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
  assign busy      = rx_ready || (state_q == RUN_RST);
  assign ProgMode  = (state_q == RUN_RST) || (state_q == RUN);
  assign cpu_reset = (state_q != RUN);
  assign load_done = (state_q == RUN);
  assign load_err  = err_q;
  assign Addr_Prog = addr_q;
  assign Data_Prog = data_q;
  assign prog_we   = we_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of random frames against a frame-level model,
// plus hand-written reset/start corner sequences.
module tb_prog_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        ProgMode;
  logic [7:0]  Addr_Prog;
  logic [31:0] Data_Prog;
  logic        prog_we;
  logic        cpu_reset;
  logic        busy;
  logic        load_done;
  logic        load_err;

  prog_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ProgMode  (ProgMode),
    .Addr_Prog (Addr_Prog),
    .Data_Prog (Data_Prog),
    .prog_we   (prog_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    int          t;
  } wr_t;

  typedef struct {
    int nw;
    bit corrupt;
    bit gaps;
    bit start_mid;
    bit exp_done;
    bit exp_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [7:0] frame_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prog_we) got_q.push_back('{Addr_Prog, Data_Prog, cyc});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      tick();
      n++;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_handshake: got no rx_ready within 20 cycles, required a handshake");
    end
  endtask

  // Frame-level model: count byte, big-endian words at addresses 0..N-1, XOR checksum.
  task automatic build_random(input int nw, input bit corrupt);
    logic [31:0] word;
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [7:0]  cnt;
    cnt = nw[7:0];
    frame_q.delete();
    exp_q.delete();
    frame_q.push_back(cnt);
    cs = 8'h00;
    for (int w = 0; w < nw; w++) begin
      word = $urandom;
      for (int k = 0; k < 4; k++) begin
        b = word[31-8*k -: 8];
        frame_q.push_back(b);
        cs ^= b;
      end
      exp_q.push_back('{w[7:0], word, 0});
    end
    if (corrupt) cs ^= (8'h01 << $urandom_range(0, 7));
    frame_q.push_back(cs);
  endtask

  task automatic send_all(input bit start_mid, input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (i == frame_q.size() - 1) start = 1'b0;
      else if (start_mid) start = 1'b1;
      if (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        tick();
      end
      send_byte(frame_q[i]);
    end
    start = 1'b0;
  endtask

  task automatic run_loaded(input bit gaps, input bit start_mid, input bit exp_done, input bit exp_err);
    got_q.delete();
    pulse_start();
    chk1("start_busy", busy, 1'b1);
    chk1("start_progmode", ProgMode, 1'b0);
    chk1("start_cpu_reset", cpu_reset, 1'b1);
    chk1("start_load_done", load_done, 1'b0);
    chk1("start_load_err", load_err, 1'b0);
    chk1("start_rx_ready", rx_ready, 1'b1);
    send_all(start_mid, gaps);
    if (exp_done) begin
      chk1("runrst1_progmode", ProgMode, 1'b1);
      chk1("runrst1_cpu_reset", cpu_reset, 1'b1);
      chk1("runrst1_busy", busy, 1'b1);
      chk1("runrst1_rx_ready", rx_ready, 1'b0);
      tick();
      chk1("runrst2_cpu_reset", cpu_reset, 1'b1);
      chk1("runrst2_load_done", load_done, 1'b0);
      tick();
      chk1("run_cpu_reset", cpu_reset, 1'b0);
      chk1("run_progmode", ProgMode, 1'b1);
      chk1("run_busy", busy, 1'b0);
    end else begin
      chk1("err_progmode", ProgMode, 1'b0);
      chk1("err_cpu_reset", cpu_reset, 1'b1);
      chk1("err_rx_ready", rx_ready, 1'b0);
      chk1("err_busy", busy, 1'b0);
    end
    chk1("final_load_done", load_done, exp_done);
    chk1("final_load_err", load_err, exp_err);
    chk("wr_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk("wr_addr", {24'b0, got_q[i].a}, {24'b0, exp_q[i].a});
      chk("wr_data", got_q[i].d, exp_q[i].d);
      if (!gaps && i > 0) chk("we_spacing", got_q[i].t - got_q[i-1].t, 4);
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3,   0, 0, 0, 1, 0};
    vecs[1] = '{3,   1, 0, 0, 0, 1};
    vecs[2] = '{1,   0, 1, 0, 1, 0};
    vecs[3] = '{256, 0, 0, 0, 1, 0};
    vecs[4] = '{5,   0, 1, 1, 1, 0};
    vecs[5] = '{2,   1, 1, 0, 0, 1};
    vecs[6] = '{17,  0, 0, 1, 1, 0};
    vecs[7] = '{255, 0, 1, 0, 1, 0};

    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();

    chk1("rst_rx_ready", rx_ready, 1'b0);
    chk1("rst_progmode", ProgMode, 1'b0);
    chk("rst_addr", {24'b0, Addr_Prog}, 32'h0);
    chk("rst_data", Data_Prog, 32'h0);
    chk1("rst_prog_we", prog_we, 1'b0);
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_load_done", load_done, 1'b0);
    chk1("rst_load_err", load_err, 1'b0);

    // Reference frame with its known-good checksum, then the same frame with a bad one
    frame_q = '{8'h03, 8'h10, 8'h20, 8'h00, 8'h07, 8'h10, 8'h40, 8'h00, 8'h08,
                8'h34, 8'h22, 8'h00, 8'h01, 8'h78};
    exp_q.delete();
    exp_q.push_back('{8'h00, 32'h10200007, 0});
    exp_q.push_back('{8'h01, 32'h10400008, 0});
    exp_q.push_back('{8'h02, 32'h34220001, 0});
    run_loaded(1'b0, 1'b0, 1'b1, 1'b0);
    frame_q[13] = 8'h79;
    run_loaded(1'b0, 1'b0, 1'b0, 1'b1);

    for (int v = 0; v < 8; v++) begin
      build_random(vecs[v].nw, vecs[v].corrupt);
      run_loaded(vecs[v].gaps, vecs[v].start_mid, vecs[v].exp_done, vecs[v].exp_err);
    end

    // Reset after the 2nd byte of the second word, with a byte still being offered
    build_random(3, 1'b0);
    got_q.delete();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(frame_q[i]);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = frame_q[7];
    tick();
    reset    = 1'b0;
    rx_valid = 1'b0;
    chk1("midrst_rx_ready", rx_ready, 1'b0);
    chk1("midrst_progmode", ProgMode, 1'b0);
    chk("midrst_addr", {24'b0, Addr_Prog}, 32'h0);
    chk("midrst_data", Data_Prog, 32'h0);
    chk1("midrst_prog_we", prog_we, 1'b0);
    chk1("midrst_cpu_reset", cpu_reset, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    tick(); tick();
    chk("midrst_wr_count", got_q.size(), 1);
    build_random(4, 1'b0);
    run_loaded(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during RUN_RST, and reset winning over a simultaneous start
    build_random(2, 1'b0);
    pulse_start();
    send_all(1'b0, 1'b0);
    chk1("rr_progmode_before", ProgMode, 1'b1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk1("rr_progmode", ProgMode, 1'b0);
    chk1("rr_cpu_reset", cpu_reset, 1'b1);
    chk1("rr_busy", busy, 1'b0);
    tick(); tick(); tick();
    chk1("rr_load_done", load_done, 1'b0);
    chk1("rr_cpu_reset_held", cpu_reset, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
